// File: rtl/fifo_uart_tx.sv
// UART-style transmitter that pops words from a synchronous FIFO and sends
// start bit, LSB-first data, optional parity and one stop bit per word.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);
  localparam bit                HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q;
  logic [BAUD_W-1:0]       baud_q;
  logic [BIT_W-1:0]        bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    parity_q;
  logic                    tx_q;
  logic                    rd_q;
  logic                    busy_q;
  logic                    done_q;

  logic pop_ok_c;
  logic baud_tc_c;

  assign pop_ok_c  = enable & ~fifo_empty;
  assign baud_tc_c = (baud_q == BAUD_LAST);

  // Frame sequencer; every output is set on the edge that enters its state.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      baud_q <= '0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop_ok_c) begin
            state_q <= S_READ;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_READ: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          shift_q  <= fifo_data;
          parity_q <= (^fifo_data) ^ PAR_ODD;
          bit_q    <= '0;
          tx_q     <= 1'b0;
          state_q  <= S_START;
        end
        S_START: begin
          if (baud_tc_c) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_tc_c) begin
            if (bit_q == BIT_LAST) begin
              if (HAS_PAR) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (baud_tc_c) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          // Registered pulse lands in the final stop cycle.
          if (baud_q == BAUD_PRE) begin
            done_q <= 1'b1;
          end
          if (baud_tc_c) begin
            if (pop_ok_c) begin
              state_q <= S_READ;
              rd_q    <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO emulation, a frame-level reference model
// compared every cycle, and literal frame checks on recorded waveforms.
module tb_fifo_uart_tx;

  localparam int unsigned DW   = 8;
  localparam int unsigned CPB  = 4;
  localparam int unsigned LOGN = 8192;

  typedef struct packed {
    logic tx;
    logic rd;
    logic busy;
    logic fd;
  } obs_t;

  localparam obs_t IDLE_OBS = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en, tx, busy, frame_done;

  logic          en_p = 1'b0;
  logic          empty_p = 1'b1;
  logic [DW-1:0] data_p = 8'h07;
  logic          rd_e, tx_e, busy_e, fd_e;
  logic          rd_o, tx_o, busy_o, fd_o;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
    .clk(clk), .rstn(rstn), .enable(en_p), .fifo_empty(empty_p), .fifo_data(data_p),
    .fifo_rd_en(rd_e), .tx(tx_e), .busy(busy_e), .frame_done(fd_e));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
    .clk(clk), .rstn(rstn), .enable(en_p), .fifo_empty(empty_p), .fifo_data(data_p),
    .fifo_rd_en(rd_o), .tx(tx_o), .busy(busy_o), .frame_done(fd_o));

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] mdl_q[$];
  obs_t          sched[$];
  obs_t          exp_o = IDLE_OBS;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic log_tx [LOGN];
  logic log_rd [LOGN];
  logic log_busy [LOGN];
  logic log_fd [LOGN];

  logic rec_te [60];
  logic rec_to [60];
  logic rec_re [60];
  logic rec_fe [60];
  logic rec_fo [60];
  logic rec_be [60];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Whole frame as one bit list: start, data LSB first, stop; each bit CPB cycles.
  function automatic void model_frame(input logic [DW-1:0] w);
    logic [9:0] bits;
    obs_t       o;
    bits = {1'b1, w, 1'b0};
    sched.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    sched.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < int'(CPB); j++) begin
        o.tx   = bits[k];
        o.rd   = 1'b0;
        o.busy = 1'b1;
        o.fd   = (k == 9) && (j == int'(CPB) - 1);
        sched.push_back(o);
      end
    end
  endfunction

  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sched.delete();
      exp_o <= IDLE_OBS;
    end else begin
      if (sched.size() == 0 && enable && mdl_q.size() != 0) model_frame(mdl_q.pop_front());
      if (sched.size() != 0) exp_o <= sched.pop_front();
      else exp_o <= IDLE_OBS;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0) || (fifo_rd_en && fifo_q.size() == 1);
  end

  always @(negedge clk) begin
    if (cyc < int'(LOGN)) begin
      log_tx[cyc]   <= tx;
      log_rd[cyc]   <= fifo_rd_en;
      log_busy[cyc] <= busy;
      log_fd[cyc]   <= frame_done;
    end
    chk("cyc_tx", 32'(tx), 32'(exp_o.tx));
    chk("cyc_rd_en", 32'(fifo_rd_en), 32'(exp_o.rd));
    chk("cyc_busy", 32'(busy), 32'(exp_o.busy));
    chk("cyc_frame_done", 32'(frame_done), 32'(exp_o.fd));
    cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    mdl_q.push_back(w);
  endtask

  function automatic int count_rd(input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) n += int'(log_rd[i]);
    return n;
  endfunction

  function automatic logic all_high(input int a, input int b, input logic sel_busy);
    logic r = 1'b1;
    for (int i = a; i < b; i++) r &= sel_busy ? log_busy[i] : log_tx[i];
    return r;
  endfunction

  function automatic logic [15:0] frame_bits(input logic [DW-1:0] w);
    return {6'b0, 1'b1, w, 1'b0};
  endfunction

  task automatic check_frame(input string nm, input int from, input logic [15:0] bits, output int c);
    int found = -1;
    for (int i = from; i < cyc && i < int'(LOGN); i++) begin
      if (log_tx[i] == 1'b0) begin
        found = i;
        break;
      end
    end
    chk({nm, "_start_seen"}, 32'(found >= 0), 32'd1);
    c = (found >= 0) ? found : from;
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_bit%0d", nm, k), 32'(log_tx[c + k * int'(CPB) + int'(CPB) / 2]), 32'(bits[k]));
    chk({nm, "_done_last"}, 32'(log_fd[c + 10 * int'(CPB) - 1]), 32'd1);
    chk({nm, "_done_early"}, 32'(log_fd[c + 10 * int'(CPB) - 2]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int from, c, c0, c1, c2, w;

    rstn   = 1'b1;
    enable = 1'b1;
    push(8'hA5);
    tick(5);
    chk("reset_no_pop", 32'(fifo_q.size()), 32'd1);

    // Single frame after reset release.
    from = cyc;
    rstn = 1'b0;
    tick(60);
    check_frame("single", from, 16'(10'b1101001010), c);
    chk("single_latency", 32'(c - from), 32'd3);
    chk("single_rd_lead", 32'(log_rd[c - 2]), 32'd1);
    chk("single_pops", 32'(count_rd(from, cyc)), 32'd1);
    chk("single_busy_after", 32'(busy), 32'd0);

    // Back-to-back frames.
    from = cyc;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    tick(140);
    check_frame("b2b0", from, frame_bits(8'h01), c0);
    check_frame("b2b1", c0 + 40, frame_bits(8'h80), c1);
    check_frame("b2b2", c1 + 40, frame_bits(8'hFF), c2);
    chk("b2b_gap0", 32'(c1 - c0), 32'd42);
    chk("b2b_gap1", 32'(c2 - c1), 32'd42);
    chk("b2b_gap_tx", {30'd0, log_tx[c0 + 40], log_tx[c0 + 41]}, 32'd3);
    chk("b2b_busy_held", 32'(all_high(c0 - 2, c2 + 40, 1'b1)), 32'd1);
    chk("b2b_busy_fall", 32'(log_busy[c2 + 40]), 32'd0);
    chk("b2b_pops", 32'(count_rd(from, cyc)), 32'd3);
    chk("b2b_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // Randomised traffic with enable toggling.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0 && fifo_q.size() < 6) push(8'($urandom));
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      tick(1);
    end
    enable = 1'b1;
    w = 0;
    while ((busy || fifo_q.size() != 0) && w < 3000) begin
      tick(1);
      w++;
    end
    chk("drain_done", 32'(w < 3000), 32'd1);
    tick(3);

    // Reset during data bit 3, then a clean frame.
    push(8'h3C);
    w = 0;
    while (tx !== 1'b0 && w < 20) begin
      tick(1);
      w++;
    end
    chk("midrst_start_seen", 32'(w < 20), 32'd1);
    tick(17);
    rstn = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd", 32'(fifo_rd_en), 32'd0);
    push(8'h55);
    tick(3);
    chk("midrst_no_pop", 32'(fifo_q.size()), 32'd1);
    from = cyc;
    rstn = 1'b0;
    tick(50);
    check_frame("after_rst", from, frame_bits(8'h55), c);
    chk("after_rst_latency", 32'(c - from), 32'd3);

    // Empty FIFO with enable high.
    from = cyc;
    tick(50);
    chk("empty_no_pop", 32'(count_rd(from, cyc)), 32'd0);
    chk("empty_tx_high", 32'(all_high(from, cyc, 1'b0)), 32'd1);

    // Enable dropped mid-frame with two words queued.
    from = cyc;
    push(8'h11);
    push(8'h22);
    w = 0;
    while (tx !== 1'b0 && w < 20) begin
      tick(1);
      w++;
    end
    chk("gate_start_seen", 32'(w < 20), 32'd1);
    tick(8);
    enable = 1'b0;
    tick(60);
    chk("gate_one_pop", 32'(count_rd(from, cyc)), 32'd1);
    chk("gate_word_left", 32'(fifo_q.size()), 32'd1);
    chk("gate_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    tick(50);
    chk("gate_resume_pops", 32'(count_rd(from, cyc)), 32'd2);
    chk("gate_resume_empty", 32'(fifo_q.size()), 32'd0);

    // Parity variants with 0x07: even parity bit 1, odd parity bit 0.
    en_p    = 1'b1;
    empty_p = 1'b0;
    tick(1);
    empty_p = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rec_te[i] = tx_e;
      rec_to[i] = tx_o;
      rec_re[i] = rd_e;
      rec_fe[i] = fd_e;
      rec_fo[i] = fd_o;
      rec_be[i] = busy_e;
    end
    en_p = 1'b0;
    chk("par_rd_pulse", {30'd0, rec_re[0], rec_re[1]}, 32'd2);
    chk("par_load_idle", 32'(rec_te[1]), 32'd1);
    chk("par_start", {30'd0, rec_te[2], rec_to[2]}, 32'd0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("par_data%0d", k), 32'(rec_te[8 + 4 * k]), 32'(data_p[k]));
    chk("par_even_bit", 32'(rec_te[40]), 32'd1);
    chk("par_odd_bit", 32'(rec_to[40]), 32'd0);
    chk("par_stop", {30'd0, rec_te[44], rec_to[44]}, 32'd3);
    chk("par_done_last", {30'd0, rec_fe[45], rec_fo[45]}, 32'd3);
    chk("par_done_early", {30'd0, rec_fe[44], rec_fo[44]}, 32'd0);
    chk("par_busy_end", {30'd0, rec_be[45], rec_be[46]}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
